// File: rtl/ibuf2bkd.sv
// ibuf2bkd: drains committed ibuf packets onto a 64-bit AXI4-Stream.
// Optional IBUF2BKD_TIMESTAMP_EN: timestamp word after header drives tuser[95:32].
module ibuf2bkd #(
  parameter int BW = 10
) (
  input  logic          clk,
  input  logic          rst,
  output logic [BW-1:0] rd_addr,
  input  logic [63:0]   rd_data,
  input  logic [BW:0]   committed_prod,
  output logic [BW:0]   committed_cons,
  output logic [63:0]   m_axis_tdata,
  output logic [7:0]    m_axis_tstrb,
  output logic [127:0]  m_axis_tuser,
  output logic          m_axis_tvalid,
  output logic          m_axis_tlast,
  input  logic          m_axis_tready,
  output logic          activity
);

  localparam int FW = BW + 1;
`ifdef IBUF2BKD_TIMESTAMP_EN
  localparam int HDR_WORDS = 2;
`else
  localparam int HDR_WORDS = 1;
`endif

  typedef enum logic [2:0] {
    IDLE, HDR_WAIT, HDR_LATCH, TS_WAIT, STREAM, COMMIT
  } state_t;

  state_t state, state_n;

  logic [15:0]  len_rd;
  logic [13:0]  words_rd;
  logic [13:0]  rd_left;
  logic [BW:0]  foot;
  logic [7:0]   last_strb;
  logic [127:0] user;
  logic         inflight, inflight_last;
  logic         issue, pop, room, empty;

  logic [63:0]  d0, d1;
  logic [7:0]   s0, s1;
  logic         l0, l1, v0, v1;
  logic [63:0]  d_new;
  logic [7:0]   s_new;

`ifdef IBUF2BKD_TIMESTAMP_EN
  logic ts_pend;
`endif

  assign empty    = committed_prod == committed_cons;
  assign len_rd   = rd_data[47:32];
  assign words_rd = 14'(({1'b0, len_rd} + 17'd7) >> 3);
  assign pop      = v0 && m_axis_tready;
  // Slots free counting data already on its way back from ibuf.
  assign room     = !(v0 && v1) && !((v0 || v1) && inflight);
  assign d_new    = rd_data;
  assign s_new    = inflight_last ? last_strb : 8'hFF;

  assign m_axis_tdata  = d0;
  assign m_axis_tstrb  = s0;
  assign m_axis_tlast  = l0;
  assign m_axis_tvalid = v0;
  assign m_axis_tuser  = user;

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    unique case (state)
      IDLE:      if (!empty) state_n = HDR_WAIT;
      HDR_WAIT:  state_n = HDR_LATCH;
      HDR_LATCH: begin
        if (len_rd == 16'd0) state_n = COMMIT;
`ifdef IBUF2BKD_TIMESTAMP_EN
        else state_n = TS_WAIT;
`else
        else state_n = STREAM;
`endif
      end
      TS_WAIT:   state_n = STREAM;
      STREAM: begin
        issue = (rd_left != 14'd0) && (room || pop);
        if (pop && l0) state_n = COMMIT;
      end
      COMMIT:    state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rd_addr        <= '0;
      committed_cons <= '0;
      rd_left        <= '0;
      foot           <= '0;
      last_strb      <= '0;
      user           <= '0;
      inflight       <= 1'b0;
      inflight_last  <= 1'b0;
      activity       <= 1'b0;
      d0 <= '0; s0 <= '0; l0 <= 1'b0; v0 <= 1'b0;
      d1 <= '0; s1 <= '0; l1 <= 1'b0; v1 <= 1'b0;
`ifdef IBUF2BKD_TIMESTAMP_EN
      ts_pend        <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      activity <= pop;
      inflight <= issue;
      if (issue) begin
        rd_addr       <= rd_addr + 1'b1;
        rd_left       <= rd_left - 14'd1;
        inflight_last <= rd_left == 14'd1;
      end
      unique case (state)
        IDLE: if (!empty) rd_addr <= committed_cons[BW-1:0];
        HDR_LATCH: begin
          rd_addr   <= rd_addr + 1'b1;
          rd_left   <= words_rd;
          foot      <= FW'({18'b0, words_rd} + 32'(HDR_WORDS));
          last_strb <= (len_rd[2:0] == 3'd0) ? 8'hFF
                     : 8'hFF >> (4'd8 - {1'b0, len_rd[2:0]});
          user      <= {96'b0, rd_data[23:16], rd_data[7:0], len_rd};
        end
`ifdef IBUF2BKD_TIMESTAMP_EN
        TS_WAIT: begin
          rd_addr <= rd_addr + 1'b1;
          ts_pend <= 1'b1;
        end
        STREAM: if (ts_pend) begin
          user[95:32] <= rd_data;
          ts_pend     <= 1'b0;
        end
`endif
        COMMIT: committed_cons <= committed_cons + foot;
        default: ;
      endcase
      // Head slot drives the bus; second slot absorbs one beat of stall.
      if (pop) begin
        if (v1) begin
          d0 <= d1; s0 <= s1; l0 <= l1;
        end
        if (inflight) begin
          if (v1) begin
            d1 <= d_new; s1 <= s_new; l1 <= inflight_last;
          end else begin
            d0 <= d_new; s0 <= s_new; l0 <= inflight_last;
          end
        end else begin
          v0 <= v1;
          v1 <= 1'b0;
        end
      end else if (inflight) begin
        if (v0) begin
          d1 <= d_new; s1 <= s_new; l1 <= inflight_last; v1 <= 1'b1;
        end else begin
          d0 <= d_new; s0 <= s_new; l0 <= inflight_last; v0 <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ibuf2bkd.sv
// tb_ibuf2bkd: directed bench for ibuf2bkd with a 16-word ibuf model.
// Exercises full/partial beats, backpressure, wrap, zero-length and reset.
module tb_ibuf2bkd;

  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BW-1:0] rd_addr;
  logic [63:0]   rd_data = '0;
  logic [BW:0]   committed_prod = '0;
  logic [BW:0]   committed_cons;
  logic [63:0]   m_axis_tdata;
  logic [7:0]    m_axis_tstrb;
  logic [127:0]  m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          activity;

  ibuf2bkd #(.BW(BW)) dut (
    .clk(clk),
    .rst(rst),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .committed_prod(committed_prod),
    .committed_cons(committed_cons),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tstrb(m_axis_tstrb),
    .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .activity(activity)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [16];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int ntot = 0;
  int npass = 0;

  logic [63:0]  bd[$];
  logic [7:0]   bs[$];
  logic         bl[$];
  logic [127:0] bu[$];
  logic [BW:0]  cons_log[$];
  int act_cnt = 0;
  int stall_err = 0;

  logic         prev_stall = 1'b0;
  logic [63:0]  pd;
  logic [7:0]   ps;
  logic         pl;
  logic [127:0] pu;
  logic [BW:0]  prev_cons = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        bd.push_back(m_axis_tdata);
        bs.push_back(m_axis_tstrb);
        bl.push_back(m_axis_tlast);
        bu.push_back(m_axis_tuser);
      end
      if (activity) act_cnt++;
      if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd ||
          m_axis_tstrb !== ps || m_axis_tlast !== pl || m_axis_tuser !== pu))
        stall_err++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata;
      ps = m_axis_tstrb;
      pl = m_axis_tlast;
      pu = m_axis_tuser;
      if (committed_cons !== prev_cons) cons_log.push_back(committed_cons);
    end
    prev_cons = committed_cons;
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] dw(input int pid, input int a);
    return {24'hDA7A00, pid[7:0], a[31:0]};
  endfunction

  function automatic logic [63:0] hdr(input logic [15:0] len,
                                      input logic [7:0] src,
                                      input logic [7:0] des);
    return {16'h0, len, 8'h0, des, 8'h0, src};
  endfunction

  task automatic put_pkt(input int ptr, input int pid, input logic [15:0] len,
                         input logic [7:0] src, input logic [7:0] des);
    int w;
    w = (int'(len) + 7) / 8;
    mem[ptr % 16] = hdr(len, src, des);
    for (int i = 0; i < w; i++)
      mem[(ptr + 1 + i) % 16] = dw(pid, (ptr + 1 + i) % 16);
  endtask

  task automatic clr();
    bd.delete(); bs.delete(); bl.delete(); bu.delete();
    cons_log.delete();
    act_cnt = 0;
    stall_err = 0;
  endtask

  task automatic wait_cons(input string tag, input logic [BW:0] exp);
    int n;
    n = 0;
    while (committed_cons !== exp && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, committed_cons, exp);
    repeat (3) @(negedge clk);
  endtask

  task automatic data_run(input string tag, input int pid, input int first,
                          input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++)
      if (i >= bd.size() || bd[i] !== dw(pid, (first + i) % 16)) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    int bad;
    int n;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_cons", committed_cons, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tuser", m_axis_tuser, 0);
    chk("rst_tstrb_tlast_act", {m_axis_tstrb, m_axis_tlast, activity}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single 64-byte packet at address 0
    put_pkt(0, 1, 16'd64, 8'd1, 8'd2);
    clr();
    committed_prod = 5'd9;
    wait_cons("t1_cons", 5'd9);
    chk("t1_beats", bd.size(), 8);
    data_run("t1_data", 1, 1, 8);
    bad = 0;
    foreach (bs[i]) if (bs[i] !== 8'hFF) bad++;
    chk("t1_strb", bad, 0);
    bad = 0;
    foreach (bl[i]) if (bl[i] !== (i == 7)) bad++;
    chk("t1_last", bad, 0);
    bad = 0;
    foreach (bu[i]) if (bu[i] !== 128'h0201_0040) bad++;
    chk("t1_user", bad, 0);
    chk("t1_act", act_cnt, 8);
    chk("t1_idle", m_axis_tvalid, 1'b0);

    // 13 bytes: partial last word
    put_pkt(9, 2, 16'd13, 8'd3, 8'd4);
    clr();
    committed_prod = 5'd12;
    wait_cons("t2_cons", 5'd12);
    chk("t2_beats", bd.size(), 2);
    data_run("t2_data", 2, 10, 2);
    chk("t2_strb", {bs[0], bs[1]}, 16'hFF1F);
    chk("t2_last", {bl[0], bl[1]}, 2'b01);

    // two zero-length packets to move cons up to 14
    mem[12] = hdr(16'd0, 8'd5, 8'd6);
    mem[13] = hdr(16'd0, 8'd7, 8'd8);
    clr();
    committed_prod = 5'd14;
    wait_cons("z_cons", 5'd14);
    chk("z_beats", bd.size(), 0);
    chk("z_steps", {cons_log.size(), cons_log[0], cons_log[1]},
        {32'd2, 5'd13, 5'd14});

    // wrap: header 14, data 15, 0, 1
    put_pkt(14, 4, 16'd24, 8'd9, 8'd10);
    clr();
    committed_prod = 5'd18;
    wait_cons("t4_cons", 5'd18);
    chk("t4_beats", bd.size(), 3);
    chk("t4_data", {bd[0], bd[1], bd[2]}, {dw(4, 15), dw(4, 0), dw(4, 1)});
    chk("t4_user", bu[2], 128'h0A09_0018);

    // backpressure: 40 bytes at address 2
    put_pkt(18, 3, 16'd40, 8'd1, 8'd1);
    clr();
    committed_prod = 5'd24;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1 m_axis_tready = (i % 3 == 0);
    end
    @(posedge clk);
    #1 m_axis_tready = 1'b1;
    wait_cons("t3_cons", 5'd24);
    chk("t3_beats", bd.size(), 5);
    data_run("t3_data", 3, 3, 5);
    chk("t3_stable", stall_err, 0);
    chk("t3_tail", {bl[4], bs[4], bl[3]}, {1'b1, 8'hFF, 1'b0});
    chk("t3_act", act_cnt, 5);

    // back-to-back: len 8, 0, 16 starting at address 8
    mem[8]  = hdr(16'd8, 8'd1, 8'd2);
    mem[9]  = dw(5, 9);
    mem[10] = hdr(16'd0, 8'd3, 8'd4);
    mem[11] = hdr(16'd16, 8'd5, 8'd6);
    mem[12] = dw(6, 12);
    mem[13] = dw(6, 13);
    clr();
    committed_prod = 5'd30;
    wait_cons("t5_cons", 5'd30);
    chk("t5_beats", bd.size(), 3);
    chk("t5_data", {bd[0], bd[1], bd[2]}, {dw(5, 9), dw(6, 12), dw(6, 13)});
    chk("t5_last", {bl[0], bl[1], bl[2]}, 3'b101);
    chk("t5_len", {bu[0][15:0], bu[1][15:0]}, {16'd8, 16'd16});
    chk("t5_steps", {cons_log.size(), cons_log[0], cons_log[1], cons_log[2]},
        {32'd3, 5'd26, 5'd27, 5'd30});

    // reset while beat 3 of a 64-byte packet is on the bus
    put_pkt(30, 7, 16'd64, 8'd1, 8'd1);
    clr();
    committed_prod = 5'd7;
    n = 0;
    while (!(bd.size() == 2 && m_axis_tvalid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach", n < 60, 1'b1);
    rst = 1'b1;
    committed_prod = '0;
    @(negedge clk);
    chk("t6_tvalid", m_axis_tvalid, 1'b0);
    chk("t6_cons", committed_cons, 0);
    chk("t6_addr", rd_addr, 0);
    rst = 1'b0;
    clr();
    repeat (10) @(negedge clk);
    chk("t6_quiet", {bd.size(), committed_cons}, {32'd0, 5'd0});

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/ibuf2bkd.md
Name: ibuf2bkd

Overview:
Transmit-side counterpart of the backend receive path. Drains committed packets from an internal buffer (ibuf) and sends them to the backend as a 64-bit AXI4-Stream.
- ibuf is written by the host-facing producer, which publishes `committed_prod`.
- This block returns freed space via `committed_cons`.
- It sits between the ibuf read port and the backend MAC/TX interface.

Parameters:
BW, 10, ibuf address width in 64-bit words. Pointers are BW+1 bits (extra wrap bit).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
rd_addr  out  BW  ibuf read address
rd_data  in  64  ibuf read data, valid exactly 1 cycle after rd_addr
committed_prod  in  BW+1  producer pointer: first word past the last fully written packet
committed_cons  out  BW+1  consumer pointer: first word not yet released
m_axis_tdata  out  64  stream data
m_axis_tstrb  out  8  byte strobes
m_axis_tuser  out  128  sideband: [15:0] len, [23:16] src_port, [31:24] des_port, [95:32] timestamp, rest 0
m_axis_tvalid  out  1  data valid
m_axis_tlast  out  1  last beat of packet
m_axis_tready  in  1  backend ready
activity  out  1  one-cycle pulse per accepted beat

Behaviour:
- Reset (synchronous, active-high): rd_addr=0, committed_cons=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tstrb=0, m_axis_tuser=0, activity=0; FSM goes to IDLE.
- Reset mid-packet: the packet is abandoned, nothing further is emitted, and the pointer restarts at 0. The producer is reset together with this block.
- Packet layout in ibuf, starting at header address H = committed_cons[BW-1:0]:
  - Word H is the header: {16'b0, len[15:0], 8'b0, des_port, 8'b0, src_port}; len is in bytes.
  - Data follows in W = ceil(len/8) words.
  - Footprint F = 1 + W words. All address arithmetic is modulo 2^BW; pointer arithmetic is modulo 2^(BW+1).
- Empty: committed_prod == committed_cons. The producer only commits whole packets, so a non-empty ibuf always holds a complete packet at H.
- FSM:
  - IDLE: if not empty, rd_addr <= H, go to HDR_WAIT.
  - HDR_WAIT: 1 cycle for read latency; go to HDR_LATCH.
  - HDR_LATCH: capture len/src/des from rd_data; set rd_addr to the first data word.
    - If len==0, go to COMMIT (zero-length packet: header skipped, no beats emitted).
    - Otherwise go to STREAM.
  - STREAM: issue data reads sequentially; data lands in a 2-entry output queue that drives m_axis.
    - A read is issued in a cycle only if (queue occupancy + reads in flight) < 2, or a beat is accepted that same cycle.
    - This sustains 1 beat/cycle with tready held high, and loses no data under arbitrary tready.
    - Go to COMMIT in the cycle after the beat with tlast is accepted.
  - COMMIT: committed_cons <= committed_cons + F; go to IDLE.
- Minimum inter-packet gap: 3 idle cycles on m_axis (COMMIT, IDLE, HDR_WAIT) plus HDR_LATCH.
- AXI rules:
  - Once tvalid is asserted, tdata/tstrb/tuser/tlast hold until tvalid&tready.
  - tvalid never depends combinationally on tready.
- tlast is set only on beat W.
- tstrb: 8'hFF on every beat except the last. On the last beat, 8'hFF if len[2:0]==0, else 8'hFF >> (8 - len[2:0]).
- tuser is constant for all beats of a packet.
- activity = registered tvalid&tready.
- committed_cons changes only in COMMIT, never mid-packet.
- Wrap-around: a packet may straddle address 2^BW-1 → 0. Reads continue at 0 with no gap.

Optional Feature:
Macro: IBUF2BKD_TIMESTAMP_EN.
- Defined: the header is followed by a 64-bit timestamp word before the data. F = 2 + W. The timestamp drives tuser[95:32] for all beats. The FSM inserts a TS_WAIT read state after HDR_LATCH, which adds 1 cycle.
- Undefined: no timestamp word. F = 1 + W; tuser[95:32] = 0.

Test Plan:
1. Single packet, tready held high: header len=64, src=1, des=2 at address 0; prod 0→9. Expect 8 beats, tstrb 8'hFF on all, tlast on beat 8, tuser[31:0]=32'h0201_0040, cons=9 after COMMIT, and 8 activity pulses.
2. Partial last word: len=13. Expect 2 beats; last tstrb=8'h1F; cons advances by 3.
3. Backpressure: len=40 with tready toggling 1,0,0,1,... Expect 5 beats in order, no duplicates or drops, and data stable while stalled.
4. Wrap: BW=4, cons=14, packet len=24 (F=4). Expect reads at addresses 14, 15, 0, 1; cons becomes 18 (wrap bit set, address 2).
5. Back-to-back plus zero-length: three packets with len 8, 0, 16. Expect beats 1 + 0 + 2; cons advances 2, 1, 3; no tvalid for the zero-length packet.
6. Reset mid-stream: assert rst during beat 3 of a len=64 packet. Next cycle: tvalid=0, cons=0, and the FSM is in IDLE.
